// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY responder with a small register file. It oversamples MDC/MDIO on clk.
// Bits are sampled on MDC rise and read data is driven on MDC fall.
module mdio_responder #(
   parameter logic [4:0]  PHY_ADDR   = 5'd1,
   parameter int          PRE_MIN    = 32,
   parameter logic [15:0] CTRL_RST   = 16'h1140,
   parameter logic [15:0] STATUS_VAL = 16'h796D,
   parameter logic [15:0] ID1_VAL    = 16'h0022,
   parameter logic [15:0] ID2_VAL    = 16'h1622
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   output logic        cfg_wr,
   output logic [4:0]  cfg_addr,
   output logic [15:0] cfg_data,
   output logic [15:0] ctrl_reg,
   output logic        soft_rst
);

   typedef enum logic [2:0] {PRE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;

   localparam logic [7:0] PRE_MIN_C = 8'(PRE_MIN);

   logic              mdc_s1_q, mdc_s2_q, mdc_s3_q, mdio_s1_q, mdio_s2_q;
   logic              mdc_rise, mdc_fall, mdio_s;
   state_t            state_q, state_d;
   logic [5:0]        bit_q, bit_d;
   logic [7:0]        pre_q, pre_d;
   logic [15:0]       sh_q, sh_d;
   logic              wr_q, wr_d;
   logic [4:0]        regad_q, regad_d;
   logic [15:0]       rd_sh_q, rd_sh_d;
   logic              oe_q, oe_d, o_q, o_d;
   logic              cfg_wr_q, cfg_wr_d, soft_q, soft_d;
   logic [4:0]        cfg_addr_q, cfg_addr_d;
   logic [15:0]       cfg_data_q, cfg_data_d, ctrl_q, ctrl_d;
   logic [3:0][15:0]  gp_q, gp_d;
   logic [4:0]        ra_new;
   logic [15:0]       rd_val, wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdc_s1_q  <= 1'b0;
         mdc_s2_q  <= 1'b0;
         mdc_s3_q  <= 1'b0;
         mdio_s1_q <= 1'b1;
         mdio_s2_q <= 1'b1;
      end else begin
         mdc_s1_q  <= mdc;
         mdc_s2_q  <= mdc_s1_q;
         mdc_s3_q  <= mdc_s2_q;
         mdio_s1_q <= mdio_i;
         mdio_s2_q <= mdio_s1_q;
      end
   end

   assign mdc_rise = mdc_s2_q & ~mdc_s3_q;
   assign mdc_fall = ~mdc_s2_q & mdc_s3_q;
   assign mdio_s   = mdio_s2_q;

   // Register address completes on the current bit; read data is snapshotted from it.
   assign ra_new = {sh_q[3:0], mdio_s};
   assign wdata  = {sh_q[14:0], mdio_s};

   always_comb begin
      rd_val = 16'h0000;
      case (ra_new)
         5'd0:    rd_val = ctrl_q;
         5'd1:    rd_val = STATUS_VAL;
         5'd2:    rd_val = ID1_VAL;
         5'd3:    rd_val = ID2_VAL;
         5'd4, 5'd5, 5'd6, 5'd7: rd_val = gp_q[ra_new[1:0]];
         default: rd_val = 16'h0000;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      pre_d      = pre_q;
      sh_d       = sh_q;
      wr_d       = wr_q;
      regad_d    = regad_q;
      rd_sh_d    = rd_sh_q;
      oe_d       = oe_q;
      o_d        = o_q;
      cfg_wr_d   = 1'b0;
      soft_d     = 1'b0;
      cfg_addr_d = cfg_addr_q;
      cfg_data_d = cfg_data_q;
      ctrl_d     = ctrl_q;
      gp_d       = gp_q;
      if (mdc_rise) begin
         sh_d = wdata;
         if (state_q != PRE) bit_d = bit_q + 6'd1;
         // bit_q holds the number of frame bits already consumed before this one.
         case (state_q)
            PRE: begin
               if (mdio_s) begin
                  if (pre_q != 8'hFF) pre_d = pre_q + 8'd1;
               end else if (pre_q >= PRE_MIN_C) begin
                  state_d = ST;
                  bit_d   = 6'd1;
                  pre_d   = 8'd0;
               end else begin
                  pre_d = 8'd0;
               end
            end
            ST: begin
               if (mdio_s) state_d = OP;
               else begin
                  state_d = PRE;
                  pre_d   = 8'd0;
               end
            end
            OP: begin
               if (bit_q == 6'd3) begin
                  case ({sh_q[0], mdio_s})
                     2'b01: begin wr_d = 1'b1; state_d = PHYAD; end
                     2'b10: begin wr_d = 1'b0; state_d = PHYAD; end
                     default: state_d = SKIP;
                  endcase
               end
            end
            PHYAD: begin
               if (bit_q == 6'd8) state_d = (ra_new == PHY_ADDR) ? REGAD : SKIP;
            end
            REGAD: begin
               if (bit_q == 6'd13) begin
                  regad_d = ra_new;
                  rd_sh_d = rd_val;
                  state_d = TA;
               end
            end
            TA: begin
               if (bit_q == 6'd15) state_d = DATA;
            end
            DATA: begin
               if (wr_q && bit_q == 6'd31) begin
                  state_d = PRE;
                  pre_d   = 8'd0;
                  if (regad_q == 5'd0) begin
                     ctrl_d     = {1'b0, wdata[14:0]};
                     soft_d     = wdata[15];
                     cfg_wr_d   = 1'b1;
                     cfg_addr_d = regad_q;
                     cfg_data_d = wdata;
                  end else if (regad_q[4:2] == 3'b001) begin
                     gp_d[regad_q[1:0]] = wdata;
                     cfg_wr_d   = 1'b1;
                     cfg_addr_d = regad_q;
                     cfg_data_d = wdata;
                  end
               end
            end
            SKIP: begin
               if (bit_q == 6'd31) begin
                  state_d = PRE;
                  pre_d   = 8'd0;
               end
            end
            default: state_d = PRE;
         endcase
      end else if (mdc_fall && !wr_q && (state_q == TA || state_q == DATA)) begin
         if (bit_q == 6'd15) begin
            oe_d = 1'b1;
            o_d  = 1'b0;
         end else if (bit_q >= 6'd16 && bit_q <= 6'd31) begin
            o_d     = rd_sh_q[15];
            rd_sh_d = {rd_sh_q[14:0], 1'b0};
         end else if (bit_q == 6'd32) begin
            oe_d    = 1'b0;
            o_d     = 1'b1;
            state_d = PRE;
            pre_d   = 8'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= PRE;
         bit_q      <= 6'd0;
         pre_q      <= 8'd0;
         sh_q       <= 16'h0000;
         wr_q       <= 1'b0;
         regad_q    <= 5'd0;
         rd_sh_q    <= 16'h0000;
         oe_q       <= 1'b0;
         o_q        <= 1'b1;
         cfg_wr_q   <= 1'b0;
         soft_q     <= 1'b0;
         cfg_addr_q <= 5'd0;
         cfg_data_q <= 16'h0000;
         ctrl_q     <= CTRL_RST;
         gp_q       <= '0;
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         pre_q      <= pre_d;
         sh_q       <= sh_d;
         wr_q       <= wr_d;
         regad_q    <= regad_d;
         rd_sh_q    <= rd_sh_d;
         oe_q       <= oe_d;
         o_q        <= o_d;
         cfg_wr_q   <= cfg_wr_d;
         soft_q     <= soft_d;
         cfg_addr_q <= cfg_addr_d;
         cfg_data_q <= cfg_data_d;
         ctrl_q     <= ctrl_d;
         gp_q       <= gp_d;
      end
   end

   assign mdio_o   = o_q;
   assign mdio_oe  = oe_q;
   assign cfg_wr   = cfg_wr_q;
   assign cfg_addr = cfg_addr_q;
   assign cfg_data = cfg_data_q;
   assign ctrl_reg = ctrl_q;
   assign soft_rst = soft_q;

endmodule
